bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 64, max grant-hold cycles while others wait (used only with BUS_ARB_TIMEOUT_EN).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 m_req_  input  4  per-master bus request, active-low; bit i = master i.
REQ-006 m_addr  input  120  per-master word address, 30 bits each; master i at [30i+29:30i].
REQ-007 m_as_  input  4  per-master address strobe, active-low.
REQ-008 m_rw  input  4  per-master read/write; 1 = read, 0 = write.
REQ-009 m_wr_data  input  128  per-master write data, 32 bits each; master i at [32i+31:32i].
REQ-010 m_grnt_  output  4  per-master grant, active-low, registered; at most one bit low.
REQ-011 s_addr  output  30  shared-bus address.
REQ-012 s_as_  output  1  shared-bus address strobe, active-low.
REQ-013 s_rw  output  1  shared-bus read/write.
REQ-014 s_wr_data  output  32  shared-bus write data.
REQ-015 owner  output  2  index of the last/current grant holder, registered.
REQ-016 timeout_evt  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-017 State: owner register (2 bits) plus registered m_grnt_; grant valid when m_grnt_[owner]==0.
REQ-018 Hold: if the grant is valid and m_req_[owner]==0, grant and owner SHALL be unchanged next cycle.
REQ-019 Arbitration: otherwise the next grant SHALL go to the first master with req_ low, searching owner+1, owner+2, owner+3, owner (mod 4, round-robin).
REQ-020 If no master requests, all m_grnt_ SHALL go high next edge and owner SHALL keep its value.
REQ-021 Latency: request asserted in cycle N with the bus free -> grant low in cycle N+1.
REQ-022 Hand-over: owner releases req_ in cycle N while another master requests -> new grant in cycle N+1, no idle cycle.
REQ-023 Simultaneous requests from an idle bus: winner is the first in round-robin order after the current owner value.
REQ-024 Mux (combinational from registered grant): valid grant -> s_* = the owner's m_* fields; no grant -> s_addr=0, s_as_=1, s_rw=1, s_wr_data=0.
REQ-025 A master that drops req_ while not granted SHALL never be granted for that request.
REQ-026 timeout_evt SHALL be 0 whenever BUS_ARB_TIMEOUT_EN is undefined.

Reset
REQ-027 reset low at a clock edge -> m_grnt_=4'b1111, owner=0, timeout_evt=0, hold counter=0 after that edge.
REQ-028 Reset mid-transfer SHALL drop the active grant at that edge regardless of m_req_.
REQ-029 The first arbitration after reset SHALL search from master 1 (owner=0 treated as last).

Configuration
REQ-030 Macro BUS_ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL count cycles of a valid grant, clearing on every grant change or release.
REQ-031 With the macro, when counter==TIMEOUT_CYC-1 and another master requests, the grant SHALL move at that edge to the next requester in round-robin order, and timeout_evt SHALL pulse for one cycle.
REQ-032 With the macro, the counter SHALL saturate when no other master requests, and no revoke SHALL occur.
REQ-033 Without the macro, no counter SHALL exist and an owner SHALL hold the grant indefinitely.

Verification
REQ-034 Reset low 2 cycles, then m_req_=4'b1110 -> m_grnt_=4'b1110 one cycle after reset release, owner=0 (master 0 found on wrap).
REQ-035 Owner 0 holds; m_req_=4'b0100 also set, then master 0 releases -> m_grnt_=4'b1011 next cycle, owner=2.
REQ-036 All requests low from owner=2 with a release each cycle -> grant order 3,0,1,2.
REQ-037 Master 1 granted, m_addr1=30'h155, m_as_[1]=0, m_rw[1]=0, wr_data1=32'hDEADBEEF -> s_* carries these values; after release with no requests, s_as_=1, s_addr=0.
REQ-038 Reset asserted while master 3 is granted -> m_grnt_=4'b1111 and owner=0 after that edge.
REQ-039 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=4: master 0 holds, master 2 requests -> grant moves to 2 after 4 held cycles, timeout_evt=1 for exactly one cycle; without the macro master 0 keeps the grant for 100 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered active-low grants.
// Optional grant-hold timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   m_req_,
   input  logic [119:0] m_addr,
   input  logic [3:0]   m_as_,
   input  logic [3:0]   m_rw,
   input  logic [127:0] m_wr_data,
   output logic [3:0]   m_grnt_,
   output logic [29:0]  s_addr,
   output logic         s_as_,
   output logic         s_rw,
   output logic [31:0]  s_wr_data,
   output logic [1:0]   owner,
   output logic         timeout_evt
);

   logic [3:0] r_grnt;
   logic [1:0] r_owner;
   logic       w_valid;
   logic       w_tmo;
   logic       w_hold;
   logic       w_found;
   logic [1:0] w_pick;
   logic [1:0] w_cand;
   logic [3:0] w_nxt_grnt;
   logic [1:0] w_nxt_owner;

   assign w_valid = ~r_grnt[r_owner];

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] LIM = 8'(TIMEOUT_CYC - 1);

   logic [7:0] r_cnt;
   logic       r_tmo_evt;
   logic       w_other;

   assign w_other = |(~m_req_ & ~(4'b0001 << r_owner));
   assign w_tmo   = w_valid && !m_req_[r_owner]
                    && (r_cnt == LIM) && w_other;
`else
   logic w_unused_cfg;

   assign w_unused_cfg = (TIMEOUT_CYC > 0);
   assign w_tmo        = 1'b0;
`endif

   assign w_hold = w_valid && !m_req_[r_owner] && !w_tmo;

   // Search owner+1 .. owner+3, then owner itself unless it is being revoked.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_owner;
      w_cand  = r_owner;
      for (int k = 1; k <= 4; k++) begin
         w_cand = r_owner + 2'(k);
         if (!w_found && !m_req_[w_cand] && !(w_tmo && k == 4)) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      w_nxt_grnt  = 4'b1111;
      w_nxt_owner = r_owner;
      if (w_hold) begin
         w_nxt_grnt = r_grnt;
      end else if (w_found) begin
         w_nxt_grnt  = ~(4'b0001 << w_pick);
         w_nxt_owner = w_pick;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_grnt  <= 4'b1111;
         r_owner <= 2'd0;
      end else begin
         r_grnt  <= w_nxt_grnt;
         r_owner <= w_nxt_owner;
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   // Counter restarts on any grant change or release, saturates at the limit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt     <= 8'd0;
         r_tmo_evt <= 1'b0;
      end else begin
         r_tmo_evt <= w_tmo;
         if (w_nxt_grnt == 4'b1111 || w_nxt_grnt != r_grnt
             || w_nxt_owner != r_owner)
            r_cnt <= 8'd0;
         else if (r_cnt != LIM)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   assign timeout_evt = r_tmo_evt;
`else
   assign timeout_evt = 1'b0;
`endif

   always_comb begin
      s_addr    = '0;
      s_as_     = 1'b1;
      s_rw      = 1'b1;
      s_wr_data = '0;
      if (w_valid) begin
         s_addr    = m_addr[30*int'(r_owner) +: 30];
         s_as_     = m_as_[r_owner];
         s_rw      = m_rw[r_owner];
         s_wr_data = m_wr_data[32*int'(r_owner) +: 32];
      end
   end

   assign m_grnt_ = r_grnt;
   assign owner   = r_owner;

endmodule
